// File: rtl/skinny_round_ctrl_if.sv
// skinny_round_ctrl_if: call handshake and datapath control bundle for the SKINNY round controller.
interface skinny_round_ctrl_if;
    logic       start;
    logic       in_ready;
    logic       abort;
    logic       out_ready;
    logic       out_valid;
    logic       load_en;
    logic       round_en;
    logic       last_round;
    logic [5:0] round_idx;
    logic [5:0] rc;
    logic       lfsr_sel;
    logic       lfsr_en;

    modport master (
        output start, abort, out_ready,
        input  in_ready, out_valid, load_en, round_en, last_round, round_idx, rc, lfsr_sel, lfsr_en
    );
    modport slave (
        input  start, abort, out_ready,
        output in_ready, out_valid, load_en, round_en, last_round, round_idx, rc, lfsr_sel, lfsr_en
    );
endinterface

// File: rtl/skinny_round_ctrl.sv
// skinny_round_ctrl: sequences one SKINNY cipher call (load, NUM_ROUNDS rounds, hold result)
// and generates the 6-bit round constant.
module skinny_round_ctrl #(
    parameter int NUM_ROUNDS = 40
) (
    input logic                  clk,
    input logic                  rst_n,
    skinny_round_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

    state_t     state, state_nx;
    logic [5:0] cst, cst_nx, round_idx, idx_nx, rc_w;
    logic       last;

    assign rc_w = {cst[4:0], ~(cst[5] ^ cst[4])};
    assign last = (state == ROUND) && (round_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cst       <= '0;
            round_idx <= '0;
        end else begin
            state     <= state_nx;
            cst       <= cst_nx;
            round_idx <= idx_nx;
        end
    end

    // abort wins over every other transition, including round completion
    always_comb begin
        state_nx = state;
        cst_nx   = cst;
        idx_nx   = round_idx;
        if (bus.abort) begin
            state_nx = IDLE;
            cst_nx   = '0;
            idx_nx   = '0;
        end else begin
            case (state)
                IDLE:  state_nx = bus.start ? LOAD : IDLE;
                LOAD: begin
                    state_nx = ROUND;
                    cst_nx   = '0;
                    idx_nx   = '0;
                end
                ROUND: begin
                    state_nx = last ? DONE : ROUND;
                    cst_nx   = rc_w;
                    idx_nx   = last ? 6'd0 : round_idx + 6'd1;
                end
                DONE:  state_nx = bus.out_ready ? IDLE : DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready   = state == IDLE;
        bus.out_valid  = state == DONE;
        bus.load_en    = state == LOAD && !bus.abort;
        bus.round_en   = state == ROUND && !bus.abort;
        bus.lfsr_sel   = state == LOAD;
        bus.lfsr_en    = state == LOAD || state == ROUND;
        bus.last_round = last;
        bus.round_idx  = round_idx;
        bus.rc         = rc_w;
    end
endmodule
